// File: rtl/req_ack_rr_sequencer.sv
// Round-robin sequencer sharing one downstream req/ack resource between N_REQ
// pulse requesters; each request ends in an ack pulse or a timeout report.
module req_ack_rr_sequencer #(
  parameter  int N_REQ    = 4,
  parameter  int MAX_WAIT = 3,
  localparam int ID_W     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  output logic             dn_req,
  input  logic             dn_ack,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic             timeout,
  output logic [ID_W-1:0]  timeout_id
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_TOUT
  } state_t;

  state_t           state_reg, state_next;
  logic [N_REQ-1:0] pending_reg, pending_next;
  logic [ID_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [ID_W-1:0]  gnt_id_reg, gnt_id_next;
  logic [ID_W-1:0]  timeout_id_reg, timeout_id_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [ID_W-1:0]  win_idx;
  logic [ID_W-1:0]  gnt_id_inc;
  logic             serve_done;

  assign serve_done = (state_reg == S_RESP) || (state_reg == S_TOUT);
  assign gnt_id_inc = (gnt_id_reg == ID_W'(N_REQ - 1)) ? '0 : gnt_id_reg + ID_W'(1);

  // A new req pulse in the same cycle as the service clear keeps the bit set.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign pending_next[gi] = req[gi] |
                                (pending_reg[gi] & ~(serve_done && (gnt_id_reg == ID_W'(gi))));
      assign ack[gi] = (state_reg == S_RESP) && (gnt_id_reg == ID_W'(gi));
    end
  endgenerate

  // Scan from the top offset down so the lowest offset from rr_ptr wins.
  always_comb begin : arb
    int pos;
    win_idx = rr_ptr_reg;
    pos     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = int'(rr_ptr_reg) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (pending_reg[ID_W'(pos)]) win_idx = ID_W'(pos);
    end
  end

  always_comb begin
    state_next      = state_reg;
    rr_ptr_next     = rr_ptr_reg;
    gnt_id_next     = gnt_id_reg;
    timeout_id_next = timeout_id_reg;
    cnt_next        = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (|pending_reg) begin
          state_next  = S_ISSUE;
          gnt_id_next = win_idx;
        end
      end
      S_ISSUE: begin
        state_next = S_WAIT;
        cnt_next   = CNT_W'(1);
      end
      S_WAIT: begin
        if (dn_ack) begin
          state_next = S_RESP;
        end else if (cnt_reg == CNT_W'(MAX_WAIT)) begin
          state_next      = S_TOUT;
          timeout_id_next = gnt_id_reg;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_RESP, S_TOUT: begin
        state_next  = S_IDLE;
        rr_ptr_next = gnt_id_inc;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      pending_reg    <= '0;
      rr_ptr_reg     <= '0;
      gnt_id_reg     <= '0;
      timeout_id_reg <= '0;
      cnt_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      pending_reg    <= pending_next;
      rr_ptr_reg     <= rr_ptr_next;
      gnt_id_reg     <= gnt_id_next;
      timeout_id_reg <= timeout_id_next;
      cnt_reg        <= cnt_next;
    end
  end

  assign dn_req     = (state_reg == S_ISSUE);
  assign busy       = (state_reg != S_IDLE);
  assign timeout    = (state_reg == S_TOUT);
  assign gnt_id     = gnt_id_reg;
  assign timeout_id = timeout_id_reg;

endmodule

// File: tb/tb_req_ack_rr_sequencer.sv
// Self-checking bench for req_ack_rr_sequencer: directed scenarios plus random
// traffic compared against a timestamp-based service model.
`timescale 1ns/1ps
module tb_req_ack_rr_sequencer;
  localparam int N  = 4;
  localparam int MW = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic         dn_ack;
  logic [N-1:0] ack;
  logic         dn_req;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         timeout;
  logic [1:0]   timeout_id;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int since  = -1;

  // Model: pending set, pointer, and the current service described by the
  // edge it was granted (m_tg) and the edge it resolved (m_te, -1 = open).
  bit m_pend[N];
  int m_ptr, m_id, m_tg, m_te, m_toid, m_e;
  bit m_svc, m_isack;

  always #5 clk = ~clk;

  req_ack_rr_sequencer #(.N_REQ(N), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .dn_req(dn_req),
    .dn_ack(dn_ack), .gnt_id(gnt_id), .busy(busy), .timeout(timeout),
    .timeout_id(timeout_id)
  );

  always @(negedge clk) begin
    if (rst_n && ack != '0) $display("txn cycle=%0d ack=%b gnt_id=%0d", cyc, ack, gnt_id);
    if (rst_n && timeout)   $display("txn cycle=%0d timeout id=%0d", cyc, timeout_id);
  end

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    m_ptr = 0; m_id = 0; m_tg = -100; m_te = -1; m_toid = 0; m_e = 0;
    m_svc = 1'b0; m_isack = 1'b0;
  endtask

  task automatic model_step();
    bit found;
    m_e++;
    if (m_svc && m_te >= 0) begin
      m_pend[m_id] = 1'b0;
      m_ptr = (m_id + 1) % N;
      m_svc = 1'b0;
    end else if (m_svc) begin
      if (dn_ack && m_e >= m_tg + 2) begin
        m_te = m_e; m_isack = 1'b1;
      end else if (m_e == m_tg + 1 + MW) begin
        m_te = m_e; m_isack = 1'b0; m_toid = m_id;
      end
    end else begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && m_pend[(m_ptr + k) % N]) begin
          found = 1'b1; m_id = (m_ptr + k) % N;
        end
      end
      if (found) begin
        m_svc = 1'b1; m_tg = m_e; m_te = -1;
      end
    end
    for (int i = 0; i < N; i++) if (req[i]) m_pend[i] = 1'b1;
  endtask

  function automatic logic [12:0] model_view();
    logic [3:0] a;
    logic       done;
    done = m_svc && (m_te >= 0);
    a    = (done && m_isack) ? (4'b0001 << m_id) : 4'b0000;
    return {a, (m_svc && m_te < 0 && m_e == m_tg), m_svc, (done && !m_isack),
            2'(m_id), 2'(m_toid)};
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  // Answers every dn_req with dn_ack sampled one edge after dn_req is seen.
  task automatic tick_resp();
    tick();
    if (dn_req) since = 0;
    else if (since >= 0) since++;
    dn_ack = (since == 1);
  endtask

  task automatic do_reset();
    req = '0; dn_ack = 1'b0; rst_n = 1'b0; since = -1;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({ack, dn_req, busy, timeout, gnt_id, timeout_id} !== 13'd0) begin
      errors++;
      $display("FAIL reset_async got=%b exp=%b", {ack, dn_req, busy, timeout, gnt_id, timeout_id}, 13'd0);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({ack, dn_req, busy, timeout, gnt_id, timeout_id} !== 13'd0) begin
      errors++;
      $display("FAIL reset_release got=%b exp=%b", {ack, dn_req, busy, timeout, gnt_id, timeout_id}, 13'd0);
    end
  endtask

  task automatic test_single();
    logic [6:0] exp_st[5];
    exp_st = '{7'b0000_0_0_0, 7'b0000_1_1_0, 7'b0000_0_1_0, 7'b0001_0_1_0, 7'b0000_0_0_0};
    req = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      dn_ack = (k == 3);
      tick();
      req = '0;
      checks++;
      if ({ack, dn_req, busy, timeout} !== exp_st[k]) begin
        errors++;
        $display("FAIL single step=%0d got=%b exp=%b", k, {ack, dn_req, busy, timeout}, exp_st[k]);
      end
    end
    dn_ack = 1'b0;
    checks++;
    if (gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL single_gnt got=%0d exp=0", gnt_id);
    end
  endtask

  task automatic test_window();
    logic [6:0] exp_st;
    // dn_ack on the last accepted edge
    req = 4'b0010; tick(); req = '0;
    for (int k = 1; k <= 6; k++) begin
      dn_ack = (k == 5);
      tick();
      dn_ack = 1'b0;
      exp_st = (k == 1) ? 7'b0000_1_1_0 : (k == 5) ? 7'b0010_0_1_0 : (k == 6) ? 7'b0 : 7'b0000_0_1_0;
      checks++;
      if ({ack, dn_req, busy, timeout} !== exp_st) begin
        errors++;
        $display("FAIL window_edge step=%0d got=%b exp=%b", k, {ack, dn_req, busy, timeout}, exp_st);
      end
    end
    // dn_ack one edge too late
    req = 4'b0010; tick(); req = '0;
    for (int k = 1; k <= 9; k++) begin
      dn_ack = (k == 6);
      tick();
      dn_ack = 1'b0;
      exp_st = (k == 1) ? 7'b0000_1_1_0 : (k == 5) ? 7'b0000_0_1_1 : (k >= 6) ? 7'b0 : 7'b0000_0_1_0;
      checks++;
      if ({ack, dn_req, busy, timeout} !== exp_st) begin
        errors++;
        $display("FAIL window_late step=%0d got=%b exp=%b", k, {ack, dn_req, busy, timeout}, exp_st);
      end
    end
    checks++;
    if (timeout_id !== 2'd1) begin
      errors++;
      $display("FAIL timeout_id got=%0d exp=1", timeout_id);
    end
  endtask

  task automatic test_ack_held();
    logic [6:0] exp_st;
    dn_ack = 1'b1;
    for (int b = 0; b < 3; b++) begin
      req = 4'b0100; tick(); req = '0;
      for (int k = 1; k <= 5; k++) begin
        tick();
        exp_st = (k == 1) ? 7'b0000_1_1_0 : (k == 2) ? 7'b0000_0_1_0 :
                 (k == 3) ? 7'b0100_0_1_0 : 7'b0;
        checks++;
        if ({ack, dn_req, busy, timeout} !== exp_st) begin
          errors++;
          $display("FAIL ack_held blk=%0d step=%0d got=%b exp=%b", b, k, {ack, dn_req, busy, timeout}, exp_st);
        end
      end
    end
    dn_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    req = 4'b1010; tick(); req = '0;
    tick(); tick();
    checks++;
    if ({gnt_id, ack, dn_req, busy, timeout} !== {2'd3, 7'b0000_0_1_0}) begin
      errors++;
      $display("FAIL mid_wait got=%b exp=%b", {gnt_id, ack, dn_req, busy, timeout}, {2'd3, 7'b0000_0_1_0});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ack, dn_req, busy, timeout, gnt_id, timeout_id} !== 13'd0) begin
      errors++;
      $display("FAIL mid_reset got=%b exp=%b", {ack, dn_req, busy, timeout, gnt_id, timeout_id}, 13'd0);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({ack, dn_req, busy, timeout} !== 7'b0) begin
        errors++;
        $display("FAIL mid_dropped step=%0d got=%b exp=%b", k, {ack, dn_req, busy, timeout}, 7'b0);
      end
    end
  endtask

  task automatic test_rr();
    int ids[$];
    int times[$];
    int exp_ids[3];
    int id;
    int n0;
    exp_ids = '{0, 1, 3};
    do_reset();
    req = 4'b1011; tick_resp(); req = '0;
    for (int k = 0; k < 30; k++) begin
      tick_resp();
      if (ack != '0) begin
        id = -1;
        for (int i = 0; i < N; i++) if (ack == (4'b0001 << i)) id = i;
        ids.push_back(id);
        times.push_back(cyc);
      end
    end
    checks++;
    if (ids.size() != 3) begin
      errors++;
      $display("FAIL rr_count got=%0d exp=3", ids.size());
    end
    for (int i = 0; i < 3 && i < ids.size(); i++) begin
      checks++;
      if (ids[i] != exp_ids[i]) begin
        errors++;
        $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, ids[i], exp_ids[i]);
      end
      if (i > 0) begin
        checks++;
        if (times[i] - times[i-1] != 4) begin
          errors++;
          $display("FAIL rr_period idx=%0d got=%0d exp=4", i, times[i] - times[i-1]);
        end
      end
    end
    // pointer wrapped 3 -> 0
    n0 = 0;
    req = 4'b0001; tick_resp(); req = '0;
    for (int k = 0; k < 10; k++) begin
      tick_resp();
      if (ack == 4'b0001) n0++;
    end
    checks++;
    if (n0 != 1 || gnt_id !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_wrap acks=%0d gnt=%0d busy=%b exp acks=1 gnt=0 busy=0", n0, gnt_id, busy);
    end
  endtask

  task automatic test_back_to_back();
    int n_ack;
    int t_first;
    int t_second;
    n_ack = 0; t_first = 0; t_second = 0;
    do_reset();
    req = 4'b0100; tick_resp(); req = '0;
    for (int k = 0; k < 20; k++) begin
      tick_resp();
      req = '0;
      if (ack == 4'b0100) begin
        n_ack++;
        if (n_ack == 1) begin
          t_first = cyc;
          req = 4'b0100;
        end else begin
          t_second = cyc;
        end
      end
    end
    checks++;
    if (n_ack != 2) begin
      errors++;
      $display("FAIL b2b_count got=%0d exp=2", n_ack);
    end
    checks++;
    if (t_second - t_first != 4) begin
      errors++;
      $display("FAIL b2b_gap got=%0d exp=4", t_second - t_first);
    end
  endtask

  task automatic test_random();
    logic [12:0] exp_v;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      req    = 4'($urandom & $urandom);
      dn_ack = ($urandom_range(0, 2) == 0);
      tick();
      exp_v = model_view();
      checks++;
      if ({ack, dn_req, busy, timeout, gnt_id, timeout_id} !== exp_v) begin
        errors++;
        $display("FAIL random cycle=%0d got=%b exp=%b (ack,dn_req,busy,timeout,gnt,tid)",
                 cyc, {ack, dn_req, busy, timeout, gnt_id, timeout_id}, exp_v);
      end
    end
    req = '0; dn_ack = 1'b0;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; req = '0; dn_ack = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_window();
    test_ack_held();
    test_reset_mid();
    test_rr();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
